// File: rtl/mem_lsu_ctrl.sv
// mem_lsu_ctrl: MEM-stage load/store controller.
// Drives the EX/MEM memory op onto a req/gnt/rvalid data bus. It also formats
// load data, raises misaligned and access-fault traps, and requests an EX/MEM
// stall until the access has completed.
// Ports:
//   i_clk, i_rst                      clock, async active-high reset
//   i_valid, i_ls_op, i_addr, i_wdata EX/MEM memory operation
//   i_stall, i_flush                  pipeline stall (others) / kill MEM op
//   o_dmem_* / i_dmem_*               data-bus initiator interface
//   o_stall_req, o_done               hold EX/MEM / op completed
//   o_load_data                       extended load result
//   o_t_*, o_fault_addr               trap flags and mtval

package cotm32_pkg;
  typedef enum logic [3:0] {
    LSU_NONE = 4'd0,
    LSU_LB,
    LSU_LH,
    LSU_LW,
    LSU_LBU,
    LSU_LHU,
    LSU_SB,
    LSU_SH,
    LSU_SW
  } lsu_ls_op_t;
endpackage

// state | meaning
// IDLE  | no access in flight; issues aligned ops, traps misaligned ones
// REQ   | request raised, waiting for gnt
// WAIT  | granted, waiting for rvalid or timeout
// HOLD  | result registered, presented until the pipeline advances
// DRAIN | flushed op in flight; response is swallowed
module mem_lsu_ctrl
  import cotm32_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  input  lsu_ls_op_t  i_ls_op,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic        i_stall,
  input  logic        i_flush,
  output logic        o_dmem_req,
  output logic        o_dmem_we,
  output logic [31:0] o_dmem_addr,
  output logic [3:0]  o_dmem_be,
  output logic [31:0] o_dmem_wdata,
  input  logic        i_dmem_gnt,
  input  logic        i_dmem_rvalid,
  input  logic [31:0] i_dmem_rdata,
  input  logic        i_dmem_err,
  output logic        o_stall_req,
  output logic        o_done,
  output logic [31:0] o_load_data,
  output logic        o_t_load_addr_misaligned,
  output logic        o_t_store_addr_misaligned,
  output logic        o_t_load_access_fault,
  output logic        o_t_store_access_fault,
  output logic [31:0] o_fault_addr
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD, S_DRAIN} state_t;

  // Counter value on the last allowed WAIT/DRAIN cycle.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] load_q, load_d;
  logic [31:0] faddr_q, faddr_d;
  logic        lflt_q, lflt_d;
  logic        sflt_q, sflt_d;

  logic        is_load, is_store, is_half, is_word;
  logic        memop, misal, aligned_op;
  logic        timeout, resp, fault;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;
  logic [31:0] fmt_load;

  always_comb begin
    is_load  = i_ls_op inside {LSU_LB, LSU_LH, LSU_LW, LSU_LBU, LSU_LHU};
    is_store = i_ls_op inside {LSU_SB, LSU_SH, LSU_SW};
    is_half  = i_ls_op inside {LSU_LH, LSU_LHU, LSU_SH};
    is_word  = i_ls_op inside {LSU_LW, LSU_SW};
  end

  assign memop      = i_valid & (is_load | is_store);
  assign misal      = (is_half & i_addr[0]) | (is_word & (|i_addr[1:0]));
  assign aligned_op = memop & ~misal;
  assign timeout    = (cnt_q == TO_LAST);
  assign resp       = i_dmem_rvalid | timeout;
  // A real response wins over a coincident timeout.
  assign fault      = i_dmem_rvalid ? i_dmem_err : 1'b1;

  assign o_dmem_we   = is_store;
  assign o_dmem_addr = {i_addr[31:2], 2'b00};

  always_comb begin
    o_dmem_be    = 4'b0000;
    o_dmem_wdata = 32'h0;
    case (i_ls_op)
      LSU_LB, LSU_LBU, LSU_SB: begin
        o_dmem_be    = 4'b0001 << i_addr[1:0];
        o_dmem_wdata = {4{i_wdata[7:0]}};
      end
      LSU_LH, LSU_LHU, LSU_SH: begin
        o_dmem_be    = 4'b0011 << i_addr[1:0];
        o_dmem_wdata = {2{i_wdata[15:0]}};
      end
      LSU_LW, LSU_SW: begin
        o_dmem_be    = 4'b1111;
        o_dmem_wdata = i_wdata;
      end
      default: ;
    endcase
  end

  always_comb begin
    case (i_addr[1:0])
      2'd0:    rbyte = i_dmem_rdata[7:0];
      2'd1:    rbyte = i_dmem_rdata[15:8];
      2'd2:    rbyte = i_dmem_rdata[23:16];
      default: rbyte = i_dmem_rdata[31:24];
    endcase
    rhalf = i_addr[1] ? i_dmem_rdata[31:16] : i_dmem_rdata[15:0];
    case (i_ls_op)
      LSU_LB:  fmt_load = {{24{rbyte[7]}}, rbyte};
      LSU_LBU: fmt_load = {24'h0, rbyte};
      LSU_LH:  fmt_load = {{16{rhalf[15]}}, rhalf};
      LSU_LHU: fmt_load = {16'h0, rhalf};
      LSU_LW:  fmt_load = i_dmem_rdata;
      default: fmt_load = 32'h0;
    endcase
  end

  always_comb begin
    state_d                   = state_q;
    cnt_d                     = cnt_q;
    load_d                    = load_q;
    faddr_d                   = faddr_q;
    lflt_d                    = lflt_q;
    sflt_d                    = sflt_q;
    o_dmem_req                = 1'b0;
    o_done                    = 1'b0;
    o_load_data               = 32'h0;
    o_t_load_addr_misaligned  = 1'b0;
    o_t_store_addr_misaligned = 1'b0;
    o_t_load_access_fault     = 1'b0;
    o_t_store_access_fault    = 1'b0;
    o_fault_addr              = 32'h0;
    case (state_q)
      S_IDLE: begin
        if (memop && misal) begin
          o_done                    = 1'b1;
          o_t_load_addr_misaligned  = is_load;
          o_t_store_addr_misaligned = is_store;
          o_fault_addr              = i_addr;
        end else if (aligned_op && !i_flush) begin
          o_dmem_req = 1'b1;
          cnt_d      = 8'd0;
          state_d    = i_dmem_gnt ? S_WAIT : S_REQ;
        end
      end
      S_REQ: begin
        o_dmem_req = 1'b1;
        if (i_dmem_gnt) begin
          // Accepted while being killed: the access is in flight, so drain it.
          cnt_d   = 8'd0;
          state_d = i_flush ? S_DRAIN : S_WAIT;
        end else if (i_flush) begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + 8'd1;
        if (i_flush) begin
          if (resp) begin
            state_d = S_IDLE;
          end else begin
            cnt_d   = 8'd0;
            state_d = S_DRAIN;
          end
        end else if (resp) begin
          o_done                 = 1'b1;
          o_load_data            = fault ? 32'h0 : fmt_load;
          o_t_load_access_fault  = is_load & fault;
          o_t_store_access_fault = is_store & fault;
          o_fault_addr           = fault ? i_addr : 32'h0;
          if (i_stall) begin
            state_d = S_HOLD;
            load_d  = o_load_data;
            lflt_d  = o_t_load_access_fault;
            sflt_d  = o_t_store_access_fault;
            faddr_d = o_fault_addr;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_HOLD: begin
        o_done                 = 1'b1;
        o_load_data            = load_q;
        o_t_load_access_fault  = lflt_q;
        o_t_store_access_fault = sflt_q;
        o_fault_addr           = faddr_q;
        if (i_flush || !i_stall) state_d = S_IDLE;
      end
      S_DRAIN: begin
        cnt_d = cnt_q + 8'd1;
        if (resp) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign o_stall_req = (aligned_op & ~o_done & ~i_flush) | ((state_q == S_DRAIN) & memop);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      load_q  <= 32'h0;
      faddr_q <= 32'h0;
      lflt_q  <= 1'b0;
      sflt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      load_q  <= load_d;
      faddr_q <= faddr_d;
      lflt_q  <= lflt_d;
      sflt_q  <= sflt_d;
    end
  end

endmodule

// File: tb/tb_mem_lsu_ctrl.sv
// Self-checking bench for mem_lsu_ctrl: each operation is described as a
// timeline (grant delay, response delay, stall length, flush point) and the
// expected outputs for every cycle are derived from that timeline.
module tb_mem_lsu_ctrl;
  import cotm32_pkg::*;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  lsu_ls_op_t  op;
  logic [31:0] addr, wdata;
  logic        stall, flush;
  logic        dreq, dwe;
  logic [31:0] daddr, dwdata;
  logic [3:0]  dbe;
  logic        gnt, rvalid, derr;
  logic [31:0] rdata;
  logic        stall_req, done;
  logic [31:0] load_data, fault_addr;
  logic        t_lmis, t_smis, t_lflt, t_sflt;

  always #5 clk = ~clk;

  mem_lsu_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_ls_op(op), .i_addr(addr),
    .i_wdata(wdata), .i_stall(stall), .i_flush(flush),
    .o_dmem_req(dreq), .o_dmem_we(dwe), .o_dmem_addr(daddr), .o_dmem_be(dbe),
    .o_dmem_wdata(dwdata), .i_dmem_gnt(gnt), .i_dmem_rvalid(rvalid),
    .i_dmem_rdata(rdata), .i_dmem_err(derr), .o_stall_req(stall_req),
    .o_done(done), .o_load_data(load_data),
    .o_t_load_addr_misaligned(t_lmis), .o_t_store_addr_misaligned(t_smis),
    .o_t_load_access_fault(t_lflt), .o_t_store_access_fault(t_sflt),
    .o_fault_addr(fault_addr)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_acc    = 0;

  logic        exp_chk, exp_req, exp_we, exp_stall_req, exp_done, exp_load_chk;
  logic [31:0] exp_addr, exp_wdata, exp_load, exp_faddr;
  logic [3:0]  exp_be, exp_flags;  // {lmis, smis, lflt, sflt}
  logic        pin_load_en, pin_bus_en;
  logic [31:0] pin_load, pin_wdata;
  logic [3:0]  pin_be;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model helpers ----------------
  function automatic int sz(input lsu_ls_op_t o);
    case (o)
      LSU_LB, LSU_LBU, LSU_SB: return 1;
      LSU_LH, LSU_LHU, LSU_SH: return 2;
      LSU_LW, LSU_SW:          return 4;
      default:                 return 0;
    endcase
  endfunction

  function automatic bit is_ld(input lsu_ls_op_t o);
    return o inside {LSU_LB, LSU_LH, LSU_LW, LSU_LBU, LSU_LHU};
  endfunction

  function automatic bit is_st(input lsu_ls_op_t o);
    return o inside {LSU_SB, LSU_SH, LSU_SW};
  endfunction

  function automatic logic [3:0] m_be(input lsu_ls_op_t o, input logic [31:0] a);
    logic [31:0] v;
    v = ((32'd1 << sz(o)) - 32'd1) << (a % 4);
    return v[3:0];
  endfunction

  function automatic logic [31:0] m_wdata(input lsu_ls_op_t o, input logic [31:0] w);
    if (sz(o) == 1) return (w & 32'hFF) * 32'h01010101;
    if (sz(o) == 2) return (w & 32'hFFFF) * 32'h00010001;
    return w;
  endfunction

  function automatic logic [31:0] m_load(input lsu_ls_op_t o, input logic [31:0] a,
                                         input logic [31:0] r);
    logic [31:0] v, span;
    if (sz(o) == 4) return r;
    span = 32'd1 << (8 * sz(o));
    v = (r >> (8 * (a % 4))) % span;
    if ((o == LSU_LB || o == LSU_LH) && v >= span / 2) v = v - span;
    return v;
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (exp_chk) begin
      chk("req", 32'(dreq), 32'(exp_req));
      if (exp_req) begin
        chk("we", 32'(dwe), 32'(exp_we));
        chk("addr", daddr, exp_addr);
        chk("be", 32'(dbe), 32'(exp_be));
        chk("wdata", dwdata, exp_wdata);
        if (pin_bus_en) begin
          chk("pin_be", 32'(dbe), 32'(pin_be));
          chk("pin_wdata", dwdata, pin_wdata);
          chk("model_be", 32'(exp_be), 32'(pin_be));
        end
      end
      chk("stall_req", 32'(stall_req), 32'(exp_stall_req));
      chk("done", 32'(done), 32'(exp_done));
      chk("traps", 32'({t_lmis, t_smis, t_lflt, t_sflt}), 32'(exp_flags));
      chk("fault_addr", fault_addr, exp_faddr);
      if (exp_load_chk) begin
        chk("load_data", load_data, exp_load);
        if (pin_load_en) begin
          chk("pin_load", load_data, pin_load);
          chk("model_load", exp_load, pin_load);
        end
      end
      if (dreq && gnt) n_acc++;
    end
  end

  // ---------------- driver ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    exp_chk = 1'b1; exp_req = 1'b0; exp_we = 1'b0; exp_stall_req = 1'b0;
    exp_done = 1'b0; exp_load_chk = 1'b0; exp_addr = 32'h0; exp_wdata = 32'h0;
    exp_load = 32'h0; exp_faddr = 32'h0; exp_be = 4'h0; exp_flags = 4'h0;
    gnt = 1'b0; rvalid = 1'b0; derr = 1'b0; rdata = $urandom; flush = 1'b0;
    stall = 1'b0;
  endtask

  task automatic set_slot(input logic v, input lsu_ls_op_t o, input logic [31:0] a,
                          input logic [31:0] w);
    valid = v; op = o; addr = a; wdata = w;
  endtask

  task automatic run_bubble(input bit stray);
    clr();
    if ($urandom % 2) set_slot(1'b0, lsu_ls_op_t'($urandom_range(0, 8)), $urandom, $urandom);
    else              set_slot(1'b1, LSU_NONE, $urandom, $urandom);
    rvalid = stray | ($urandom % 4 == 0);
    stall  = $urandom % 2;
    flush  = $urandom % 2;
    step();
  endtask

  task automatic run_misal(input lsu_ls_op_t o, input logic [31:0] a, input int st);
    for (int h = 0; h <= st; h++) begin
      clr();
      set_slot(1'b1, o, a, $urandom);
      stall     = (h < st);
      rvalid    = ($urandom % 3 == 0);
      exp_done  = 1'b1;
      exp_flags = {is_ld(o), is_st(o), 2'b00};
      exp_faddr = a;
      step();
    end
  endtask

  // fk: 0 none, 1 flush at request-phase cycle fat (< gd),
  //     2 flush at wait cycle fat (1 <= fat < rd). rd = 0 means no response.
  task automatic run_op(input lsu_ls_op_t o, input logic [31:0] a, input logic [31:0] w,
                        input logic [31:0] rd_data, input logic e, input int gd,
                        input int rd, input int st, input int fk, input int fat);
    int  r;
    bit  flt;
    r = (rd > 0) ? rd : TO;
    for (int t = 0; t <= gd; t++) begin
      clr();
      set_slot(1'b1, o, a, w);
      exp_we = is_st(o); exp_addr = a & 32'hFFFFFFFC; exp_be = m_be(o, a);
      exp_wdata = m_wdata(o, w);
      flush  = (fk == 1 && t == fat);
      gnt    = (t == gd) && (fk != 1);
      rvalid = ($urandom % 4 == 0);
      stall  = ($urandom % 3 == 0);
      exp_req       = (t > 0) || !flush;
      exp_stall_req = !flush;
      step();
      if (flush) return;
    end
    for (int k = 1; k < r; k++) begin
      clr();
      set_slot(1'b1, o, a, w);
      flush = (fk == 2 && k == fat);
      stall = ($urandom % 3 == 0);
      exp_stall_req = !flush;
      step();
      if (flush) begin
        for (int k2 = fat + 1; k2 <= rd; k2++) begin
          clr();
          set_slot($urandom % 2, lsu_ls_op_t'($urandom_range(0, 8)), $urandom, $urandom);
          stall  = $urandom % 2;
          rvalid = (k2 == rd);
          derr   = $urandom % 2;
          exp_stall_req = valid && (op != LSU_NONE);
          step();
        end
        return;
      end
    end
    flt = (rd == 0) || e;
    for (int h = 0; h <= st; h++) begin
      clr();
      set_slot(1'b1, o, a, w);
      if (h == 0) begin
        rvalid = (rd > 0);
        derr   = e;
        rdata  = rd_data;
      end
      stall        = (h < st);
      exp_done     = 1'b1;
      exp_flags    = {2'b00, is_ld(o) && flt, is_st(o) && flt};
      exp_faddr    = flt ? a : 32'h0;
      exp_load_chk = is_ld(o) && !flt;
      exp_load     = m_load(o, a, rd_data);
      step();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    pin_load_en = 1'b0; pin_bus_en = 1'b0; pin_load = 0; pin_be = 0; pin_wdata = 0;
    rst = 1'b1;
    clr();
    set_slot(1'b0, LSU_NONE, 32'h0, 32'h0);
    #1;
    for (int i = 0; i < 3; i++) step();
    rst = 1'b0;

    // LW 0x100, granted at once, data next cycle
    pin_load_en = 1'b1; pin_load = 32'hDEADBEEF;
    run_op(LSU_LW, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0, 0, 1, 0, 0, 0);
    // LB / LBU at 0x103
    pin_load = 32'hFFFFFF80;
    run_op(LSU_LB, 32'h103, 32'h0, 32'h80FFFFFF, 1'b0, 1, 2, 0, 0, 0);
    pin_load = 32'h00000080;
    run_op(LSU_LBU, 32'h103, 32'h0, 32'h80FFFFFF, 1'b0, 0, 1, 1, 0, 0);
    pin_load_en = 1'b0;
    // SH at 0x102
    pin_bus_en = 1'b1; pin_be = 4'b1100; pin_wdata = 32'hABCDABCD;
    n_acc = 0;
    run_op(LSU_SH, 32'h102, 32'h1234ABCD, 32'h0, 1'b0, 0, 1, 0, 0, 0);
    chk("sh_one_req", 32'(n_acc), 32'd1);
    pin_bus_en = 1'b0;
    // misaligned LW
    run_misal(LSU_LW, 32'h102, 0);
    // SW timeout then a stray response
    run_op(LSU_SW, 32'h40, 32'h55, 32'h0, 1'b0, 0, 0, 0, 0, 0);
    run_bubble(1'b1);
    // response under a 3-cycle stall
    n_acc = 0;
    run_op(LSU_LW, 32'h200, 32'h0, 32'h13579BDF, 1'b0, 0, 2, 3, 0, 0);
    chk("hold_one_req", 32'(n_acc), 32'd1);
    // flush while waiting, flush before grant
    run_op(LSU_LW, 32'h300, 32'h0, 32'h1, 1'b0, 0, 4, 0, 2, 2);
    run_op(LSU_SB, 32'h301, 32'h77, 32'h0, 1'b0, 2, 1, 0, 1, 1);
    run_bubble(1'b0);

    for (int it = 0; it < 300; it++) begin
      int kind;
      kind = $urandom_range(0, 9);
      if (kind < 2) begin
        run_bubble(1'b0);
      end else if (kind == 2) begin
        lsu_ls_op_t o;
        logic [31:0] a;
        o = ($urandom % 2) ? (($urandom % 2) ? LSU_LH : LSU_SH)
                           : (($urandom % 2) ? LSU_LW : LSU_SW);
        if ($urandom % 2) o = ($urandom % 2) ? LSU_LHU : o;
        a = $urandom;
        if (sz(o) == 2) a[0] = 1'b1;
        else if (a[1:0] == 2'b00) a[0] = 1'b1;
        run_misal(o, a, $urandom_range(0, 2));
      end else begin
        lsu_ls_op_t o;
        logic [31:0] a;
        int gd, rd, fk, fat;
        o  = lsu_ls_op_t'($urandom_range(1, 8));
        a  = $urandom;
        a  = a - (a % sz(o));
        gd = $urandom_range(0, 3);
        rd = ($urandom % 8 == 0) ? 0 : $urandom_range(1, 5);
        fk = 0; fat = 0;
        if ($urandom % 6 == 0 && gd >= 1) begin
          fk = 1; fat = $urandom_range(0, gd - 1);
        end else if ($urandom % 5 == 0 && rd >= 2) begin
          fk = 2; fat = $urandom_range(1, rd - 1);
        end
        run_op(o, a, $urandom, $urandom, ($urandom % 4 == 0), gd, rd,
               $urandom_range(0, 3), fk, fat);
      end
    end

    exp_chk = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
